instruction_loader: RTL and testbench
=====================================

// Module: instruction_loader
// PURPOSE
//   Write-side counterpart of the instruction memory: accepts a program as a byte stream
//   over a valid/ready handshake and packs it big-endian into 32-bit words.
//   Writes each word into the writable instruction memory at incrementing addresses from 0.
//   Holds the CPU stalled while loading; the fetch path then reads the stored program.
// PARAMETERS
//   address_length  3  instruction memory address width; depth = 2**address_length words
// PORTS
//   clk               in   1                 single clock, rising edge
//   rst_n             in   1                 asynchronous, active-low reset
//   start             in   1                 one-cycle pulse; begins a load when idle
//   num_words         in   address_length+1  program length in words, sampled on start
//   byte_data         in   8                 program byte, MSB of each word first
//   byte_valid        in   1                 byte_data valid
//   byte_ready        out  1                 loader accepts byte this cycle
//   mem_write_enable  out  1                 one-cycle write strobe to instruction memory
//   mem_write_address out  address_length    word address of write
//   mem_write_data    out  32                assembled instruction word
//   cpu_hold          out  1                 high from accepted start until load completes
//   busy              out  1                 state != IDLE
//   done              out  1                 one-cycle pulse after the last word is written
//   error             out  1                 one-cycle pulse when a start is rejected
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; every output 0; byte counter, word index and
//     packing register cleared. Reset mid-load abandons the load, and no strobe is issued.
//   - Byte transfer happens when byte_valid && byte_ready. byte_ready=1 only in RECV.
//   - FSM states:
//     IDLE  -> RECV on start with 1 <= num_words <= 2**address_length. Latch num_words,
//              word index=0, cpu_hold=1.
//           -> stays IDLE on start with num_words==0 or num_words > depth; error=1 next cycle.
//     RECV  collects 4 bytes. The first byte fills [31:24] and the last fills [7:0]. On the
//           4th transfer -> WRITE.
//     WRITE mem_write_enable=1 for exactly one cycle, with address = word index and the data
//           fixed. Then -> DONE if index == num_words-1, else index+1 -> RECV.
//     DONE  done=1 and cpu_hold=0 for one cycle -> IDLE.
//   - Latency: the strobe is asserted the cycle after the 4th byte transfer.
//     Minimum 5 cycles per word, because byte_ready=0 in WRITE.
//   - start while busy: ignored, with no error and no restart.
//   - byte_valid while not RECV: ignored; the byte is not consumed.
//   - Word index never wraps. num_words == depth writes exactly addresses 0..depth-1.
//   - num_words is compared at address_length+1 bits, with no truncation.
//   - mem_write_address/data hold their last values when the strobe is low.
//   - Simultaneous start and rst_n low: reset wins.
// STRUCTURE
//   Shared package: state encoding (IDLE, RECV, WRITE, DONE) and BYTES_PER_WORD=4.
//   Sub-module byte_word_packer: a 2-bit byte counter and a 32-bit shift register.
//   - Inputs: byte strobe, clear.
//   - Outputs: word and word_complete.
//   The FSM, word index and handshake stay in instruction_loader.
// TESTING
//   1 Load 4 words (num_words=4): 2C00000A 2C010001 08210001 18017FFF, streamed byte-wise
//     with byte_valid always high -> 4 strobes at addresses 0..3 with those data;
//     done pulses once; cpu_hold is high throughout and then 0.
//   2 Same program with byte_valid toggled randomly (50%) -> identical writes;
//     no byte lost or duplicated; byte_ready=0 in every WRITE cycle.
//   3 start with num_words=0, then with num_words=9 (depth 8) -> error pulse each time,
//     busy stays 0, no strobe.
//   4 Full depth, num_words=8, word k = 0x0000000k -> addresses 0..7 written, no wrap,
//     done after the address-7 strobe.
//   5 start pulsed during RECV of word 1 -> ignored; the load completes normally.
//   6 rst_n low after 2 bytes of word 2 -> all outputs 0 immediately. A new load of
//     1 word 0xDEADBEEF writes address 0 with 0xDEADBEEF and no stale bytes.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and word geometry.
package instruction_loader_pkg;

    localparam int ADDRESS_LENGTH = 3;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream, control and instruction-memory write signals of the loader.
interface instruction_loader_if #(
    parameter int address_length = 3
);
    logic                      start;
    logic [address_length:0]   num_words;
    logic [7:0]                byte_data;
    logic                      byte_valid;
    logic                      byte_ready;
    logic                      mem_write_enable;
    logic [address_length-1:0] mem_write_address;
    logic [31:0]               mem_write_data;
    logic                      cpu_hold;
    logic                      busy;
    logic                      done;
    logic                      error;

    modport master (
        output start, num_words, byte_data, byte_valid,
        input  byte_ready, mem_write_enable, mem_write_address, mem_write_data,
               cpu_hold, busy, done, error
    );

    modport slave (
        input  start, num_words, byte_data, byte_valid,
        output byte_ready, mem_write_enable, mem_write_address, mem_write_data,
               cpu_hold, busy, done, error
    );

endinterface

// File: rtl/instruction_loader_byte_word_packer.sv
// Packs a byte stream big-endian into 32-bit words; first byte lands in [31:24].
module byte_word_packer
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_strobe,
    input  logic        clear,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_complete
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  count;
    logic [31:0] shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            shift <= 32'd0;
        end else if (clear) begin
            count <= 2'd0;
            shift <= 32'd0;
        end else if (byte_strobe) begin
            count <= count + 2'd1;
            shift <= {shift[23:0], byte_data};
        end
    end

    assign word          = shift;
    assign word_complete = byte_strobe && (count == LAST_BYTE);

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte-streamed program into instruction memory while holding the CPU stalled.
//   state | meaning
//   IDLE  | waiting for start; rejects bad lengths with an error pulse
//   RECV  | accepting bytes of the current word
//   WRITE | one-cycle write strobe for the assembled word
//   DONE  | one-cycle completion pulse, CPU released
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int address_length = ADDRESS_LENGTH
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_loader_if.slave bus
);

    localparam logic [address_length:0]   DEPTH     = {1'b1, {address_length{1'b0}}};
    localparam logic [address_length:0]   LEN_ONE   = {{address_length{1'b0}}, 1'b1};
    localparam logic [address_length-1:0] INDEX_ONE = {{(address_length-1){1'b0}}, 1'b1};

    state_t                    state, state_next;
    logic [address_length:0]   num_words_q;
    logic [address_length-1:0] index;
    logic [address_length-1:0] addr_hold;
    logic [31:0]               data_hold;
    logic                      error_q;
    logic                      len_ok;
    logic                      start_ok;
    logic                      transfer;
    logic                      last_word;
    logic [31:0]               word;
    logic                      word_complete;

    // num_words is compared at full width so depth+1 is rejected, not wrapped to 0.
    assign len_ok    = (bus.num_words != '0) && (bus.num_words <= DEPTH);
    assign start_ok  = (state == IDLE) && bus.start && len_ok;
    assign transfer  = bus.byte_valid && (state == RECV);
    assign last_word = ({1'b0, index} == (num_words_q - LEN_ONE));

    byte_word_packer u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .byte_strobe   (transfer),
        .clear         (start_ok),
        .byte_data     (bus.byte_data),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next            = state;
        bus.byte_ready        = 1'b0;
        bus.mem_write_enable  = 1'b0;
        bus.mem_write_address = addr_hold;
        bus.mem_write_data    = data_hold;
        bus.cpu_hold          = 1'b0;
        bus.busy              = (state != IDLE);
        bus.done              = 1'b0;
        bus.error             = error_q;
        case (state)
            IDLE: begin
                if (start_ok) state_next = RECV;
            end
            RECV: begin
                bus.byte_ready = 1'b1;
                bus.cpu_hold   = 1'b1;
                if (word_complete) state_next = WRITE;
            end
            WRITE: begin
                bus.mem_write_enable  = 1'b1;
                bus.mem_write_address = index;
                bus.mem_write_data    = word;
                bus.cpu_hold          = 1'b1;
                state_next            = last_word ? DONE : RECV;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address/data outputs replay the last written word while the strobe is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_words_q <= '0;
            index       <= '0;
            addr_hold   <= '0;
            data_hold   <= 32'd0;
            error_q     <= 1'b0;
        end else begin
            error_q <= (state == IDLE) && bus.start && !len_ok;
            if (start_ok) begin
                num_words_q <= bus.num_words;
                index       <= '0;
            end else if (state == WRITE) begin
                addr_hold <= index;
                data_hold <= word;
                if (!last_word) index <= index + INDEX_ONE;
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench: directed and randomized program loads against a word-list model.
module tb_instruction_loader;
    import instruction_loader_pkg::*;

    localparam int AL    = 3;
    localparam int DEPTH = 1 << AL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_loader_if #(.address_length(AL)) bus ();

    instruction_loader #(.address_length(AL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int          obs_addr[$];
    logic [31:0] obs_data[$];
    int          done_cnt   = 0;
    int          err_cnt    = 0;
    int          ready_viol = 0;
    int          hold_viol  = 0;
    logic [31:0] cur_prog[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_write_enable) begin
                obs_addr.push_back(int'(bus.mem_write_address));
                obs_data.push_back(bus.mem_write_data);
                if (bus.byte_ready) ready_viol++;
                if (!bus.cpu_hold) hold_viol++;
            end
            if (bus.done) begin
                done_cnt++;
                if (bus.cpu_hold) hold_viol++;
            end
            if (bus.error) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.byte_ready, bus.mem_write_enable, bus.mem_write_address, bus.mem_write_data,
                    bus.cpu_hold, bus.busy, bus.done, bus.error});
    endfunction

    task automatic do_start(input int nw);
        bus.num_words = (AL+1)'(nw);
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit sent  = 1'b0;
        int guard = 0;
        while (!sent) begin
            bus.byte_data  = b;
            bus.byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bus.byte_valid && bus.byte_ready) sent = 1'b1;
            @(posedge clk); #1;
            guard++;
            if (!sent && guard > 300) begin
                checks++;
                errors++;
                $error("FAIL byte_timeout: observed no transfer expected transfer of %0h", b);
                sent = 1'b1;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int first, input int last, input bit rnd);
        for (int i = first; i <= last; i++) send_byte(w[31 - 8*i -: 8], rnd);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_writes(input string tag, input int base);
        check({tag, "_count"}, 64'(obs_addr.size() - base), 64'(cur_prog.size()));
        for (int k = 0; k < cur_prog.size() && base + k < obs_addr.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), 64'(obs_addr[base + k]), 64'(k));
            check($sformatf("%s_data%0d", tag, k), 64'(obs_data[base + k]), 64'(cur_prog[k]));
        end
    endtask

    task automatic run_load(input string tag, input bit rnd);
        int base = obs_addr.size();
        int d0   = done_cnt;
        int e0   = err_cnt;
        do_start(cur_prog.size());
        check({tag, "_hold_start"}, 64'(bus.cpu_hold), 64'd1);
        foreach (cur_prog[k]) send_word(cur_prog[k], 0, 3, rnd);
        wait_idle(tag);
        check_writes(tag, base);
        check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_no_error"}, 64'(err_cnt - e0), 64'd0);
        check({tag, "_hold_end"}, 64'(bus.cpu_hold), 64'd0);
        check({tag, "_last_addr"}, 64'(bus.mem_write_address), 64'(cur_prog.size() - 1));
        check({tag, "_last_data"}, 64'(bus.mem_write_data), 64'(cur_prog[cur_prog.size() - 1]));
    endtask

    initial begin
        int base;
        int d0;
        int e0;
        int nw;

        bus.start      = 1'b0;
        bus.num_words  = '0;
        bus.byte_data  = 8'd0;
        bus.byte_valid = 1'b0;

        #2;
        check("reset_outputs", all_outputs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_outputs", all_outputs(), 64'd0);

        cur_prog = '{32'h2C00000A, 32'h2C010001, 32'h08210001, 32'h18017FFF};
        run_load("prog", 1'b0);
        check("prog_hold_during_write", 64'(hold_viol), 64'd0);

        run_load("prog_rnd", 1'b1);
        check("rnd_ready_in_write", 64'(ready_viol), 64'd0);

        base = obs_addr.size();
        e0   = err_cnt;
        do_start(0);
        check("len0_error", 64'(bus.error), 64'd1);
        check("len0_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        check("len0_error_pulse", 64'(bus.error), 64'd0);
        do_start(DEPTH + 1);
        check("len9_error", 64'(bus.error), 64'd1);
        check("len9_busy", 64'(bus.busy), 64'd0);
        bus.byte_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        check("bad_len_errors", 64'(err_cnt - e0), 64'd2);
        check("bad_len_no_write", 64'(obs_addr.size() - base), 64'd0);
        check("bad_len_idle", 64'(bus.busy), 64'd0);

        cur_prog.delete();
        for (int k = 0; k < DEPTH; k++) cur_prog.push_back(32'(k));
        run_load("full", 1'b0);

        cur_prog = '{32'h2C00000A, 32'h2C010001, 32'h08210001, 32'h18017FFF};
        base = obs_addr.size();
        d0   = done_cnt;
        e0   = err_cnt;
        do_start(4);
        send_word(cur_prog[0], 0, 3, 1'b0);
        send_word(cur_prog[1], 0, 1, 1'b0);
        do_start(2);
        check("restart_busy", 64'(bus.busy), 64'd1);
        send_word(cur_prog[1], 2, 3, 1'b0);
        send_word(cur_prog[2], 0, 3, 1'b1);
        send_word(cur_prog[3], 0, 3, 1'b0);
        wait_idle("restart");
        check_writes("restart", base);
        check("restart_done", 64'(done_cnt - d0), 64'd1);
        check("restart_no_error", 64'(err_cnt - e0), 64'd0);

        base = obs_addr.size();
        do_start(4);
        send_word(cur_prog[0], 0, 3, 1'b0);
        send_word(cur_prog[1], 0, 3, 1'b0);
        send_word(cur_prog[2], 0, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", all_outputs(), 64'd0);
        check("midreset_writes", 64'(obs_addr.size() - base), 64'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cur_prog = '{32'hDEADBEEF};
        run_load("after_reset", 1'b0);

        for (int r = 0; r < 3; r++) begin
            nw = int'($urandom_range(1, DEPTH));
            cur_prog.delete();
            for (int k = 0; k < nw; k++) cur_prog.push_back($urandom);
            run_load($sformatf("rand%0d", r), 1'b1);
        end
        check("final_ready_in_write", 64'(ready_viol), 64'd0);
        check("final_hold_violations", 64'(hold_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
